pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8'd255, maximum MEM_WAIT cycles before the block forces release (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: lu_hazard  input  1  load-use hazard detected for the ID-stage instruction.
REQ-005 Port: branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-006 Port: dmem_req  input  1  MEM-stage instruction accesses data memory this cycle.
REQ-007 Port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-008 Port: pc_write  output  1  PC register load enable.
REQ-009 Port: ifid_write  output  1  IF/ID register load enable.
REQ-010 Port: ifid_flush  output  1  IF/ID register cleared to NOP.
REQ-011 Port: idex_flush  output  1  ID/EX control cleared to a bubble.
REQ-012 Port: pipe_hold  output  1  ID/EX, EX/MEM and MEM/WB registers hold their contents.
REQ-013 Port: mem_err  output  1  one-cycle pulse on a MEM_WAIT timeout.
REQ-014 Port: stall_cycles  output  16  saturating count of cycles with pc_write=0 (present only with STALL_CNT_EN).

Function
REQ-015 The FSM SHALL have four states: RUN, MEM_WAIT, FLUSH and LU_BUBBLE.
REQ-016 The default outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, pipe_hold=0 and mem_err=0; all outputs are combinational from state and inputs.
REQ-017 In RUN, if dmem_req=1 and dmem_ready=0, the block SHALL drive pc_write=0, ifid_write=0 and pipe_hold=1, and go to MEM_WAIT.
REQ-018 In RUN, otherwise, if branch_taken=1, the block SHALL drive ifid_flush=1 and idex_flush=1 (pc_write=1), and go to FLUSH.
REQ-019 In RUN, otherwise, if lu_hazard=1, the block SHALL drive pc_write=0, ifid_write=0 and idex_flush=1, and go to LU_BUBBLE.
REQ-020 In RUN, otherwise, the block SHALL drive the defaults and stay in RUN.
REQ-021 Priority SHALL be memory wait over branch over load-use; lower-priority events in the same cycle are ignored.
REQ-022 In MEM_WAIT, while dmem_ready=0, the block SHALL drive the freeze outputs (pc_write=0, ifid_write=0, pipe_hold=1) and ignore branch_taken and lu_hazard.
REQ-023 In MEM_WAIT, on the dmem_ready=1 cycle (the release cycle), the block SHALL apply the RUN branch/load-use/default rules of REQ-018 to REQ-020 with pipe_hold=0, including their next-state transitions.
REQ-024 A wait counter SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT.
REQ-025 When the wait counter reaches MEM_TIMEOUT with dmem_ready=0, the block SHALL pulse mem_err=1 and treat that cycle as a release cycle.
REQ-026 FLUSH SHALL last exactly one cycle, drive ifid_flush=1 with the other outputs at defaults, ignore all inputs, and return to RUN.
REQ-027 LU_BUBBLE SHALL last exactly one cycle, drive the defaults, and ignore lu_hazard.
REQ-028 In LU_BUBBLE, dmem_req=1 with dmem_ready=0 SHALL still enter MEM_WAIT, and branch_taken=1 SHALL still act as in REQ-018.
REQ-029 Back-to-back load-use hazards SHALL cost exactly one bubble each, with RUN re-evaluated after LU_BUBBLE.

Reset
REQ-030 While rst_n=0, the state SHALL be RUN and the wait counter 0.
REQ-031 While rst_n=0, the outputs SHALL be forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, mem_err=0 and stall_cycles=0.
REQ-032 Reset asserted in any state, including mid MEM_WAIT, SHALL abandon the sequence immediately with no pending flush or bubble retained.
REQ-033 On the first edge after rst_n deasserts, the block SHALL operate from RUN.

Configuration
REQ-034 With macro PIPELINE_STALL_CNT_EN defined, stall_cycles SHALL increment on every clock where pc_write=0 and saturate at 16'hFFFF.
REQ-035 Without PIPELINE_STALL_CNT_EN, the stall_cycles port and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-036 lu_hazard=1 for one cycle in RUN -> that cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle defaults; stall_cycles +1.
REQ-037 dmem_req=1 with dmem_ready=0 for 3 cycles then 1 -> 3 cycles with pipe_hold=1 and pc_write=0, release on the 4th cycle, mem_err never asserted.
REQ-038 branch_taken=1 and lu_hazard=1 together in RUN -> ifid_flush=1 and idex_flush=1 with pc_write=1, then FLUSH for one cycle (ifid_flush=1), then RUN; no bubble issued.
REQ-039 MEM_TIMEOUT=4 with dmem_ready held 0 -> mem_err pulses once on the 4th MEM_WAIT cycle, then the block returns to RUN.
REQ-040 rst_n asserted during MEM_WAIT -> outputs go immediately to reset values; after deassertion, with inputs low, the next cycle shows defaults.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: memory-wait freeze, branch flush and load-use bubble.
// Optional saturating stall-cycle counter enabled by macro PIPELINE_STALL_CNT_EN.
module pipeline_stall_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_hazard,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        mem_err,
    output logic [1:0]  dbg_state
`ifdef PIPELINE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        FLUSH     = 2'd2,
        LU_BUBBLE = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic timeout;
    logic hold;

    assign mem_stall = dmem_req & ~dmem_ready;
    // Timeout fires on the MEM_TIMEOUT-th cycle spent in MEM_WAIT and releases like dmem_ready.
    assign timeout   = (state_q == MEM_WAIT) && !dmem_ready && ((wait_cnt_q + 8'd1) == MEM_TIMEOUT);
    assign hold      = (state_q == MEM_WAIT) && !dmem_ready && !timeout;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        case (state_q)
            RUN: begin
                if (mem_stall)         state_d = MEM_WAIT;
                else if (branch_taken) state_d = FLUSH;
                else if (lu_hazard)    state_d = LU_BUBBLE;
                else                   state_d = RUN;
            end
            MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (hold)              state_d = MEM_WAIT;
                else if (branch_taken) state_d = FLUSH;
                else if (lu_hazard)    state_d = LU_BUBBLE;
                else                   state_d = RUN;
            end
            FLUSH: begin
                state_d = RUN;
            end
            LU_BUBBLE: begin
                if (mem_stall)         state_d = MEM_WAIT;
                else if (branch_taken) state_d = FLUSH;
                else                   state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu_hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_err = timeout;
                if (hold) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu_hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            FLUSH: begin
                ifid_flush = 1'b1;
            end
            LU_BUBBLE: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            default: ;
        endcase
        // Reset overrides everything so the front end sees a flushed, frozen pipe.
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
            mem_err    = 1'b0;
        end
    end

`ifdef PIPELINE_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'd0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl built with MEM_TIMEOUT=4.
// Output vector order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err}.
module tb_pipeline_stall_ctrl;

  localparam logic [5:0] O_DEF = 6'b110000;
  localparam logic [5:0] O_FRZ = 6'b000010;
  localparam logic [5:0] O_BR  = 6'b111100;
  localparam logic [5:0] O_LU  = 6'b000100;
  localparam logic [5:0] O_FL  = 6'b111000;
  localparam logic [5:0] O_RST = 6'b001100;
  localparam logic [5:0] O_ERR = 6'b110001;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_FL  = 2'd2;
  localparam logic [1:0] S_LU  = 2'd3;

  logic clk;
  logic rst_n;
  logic lu_hazard, branch_taken, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err;
  logic [1:0] dbg_state;
  logic [5:0] outs;
  int checks;
  int errors;
  int stall_exp;
`ifdef PIPELINE_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  pipeline_stall_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lu_hazard    (lu_hazard),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .pipe_hold    (pipe_hold),
    .mem_err      (mem_err),
    .dbg_state    (dbg_state)
`ifdef PIPELINE_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag);
`ifdef PIPELINE_STALL_CNT_EN
    chk({tag, "_stall"}, stall_cycles, stall_exp[15:0]);
`endif
  endtask

  // One cycle: drive inputs mid-period, check comb outputs and current state before the edge.
  task automatic cyc(input string tag, input logic lu, input logic br, input logic req,
                     input logic rdy, input logic [5:0] exp_o, input logic [1:0] exp_s);
    @(negedge clk);
    lu_hazard    = lu;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    #1;
    chk({tag, "_out"}, {10'd0, outs}, {10'd0, exp_o});
    chk({tag, "_st"}, {14'd0, dbg_state}, {14'd0, exp_s});
    chk_stall(tag);
    if (exp_o[5] == 1'b0) stall_exp++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stall_exp = 0;
    rst_n = 1'b0;
    lu_hazard = 1'b0;
    branch_taken = 1'b0;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("rst_out", {10'd0, outs}, {10'd0, O_RST});
    chk("rst_st", {14'd0, dbg_state}, {14'd0, S_RUN});
    repeat (2) @(posedge clk);
    @(negedge clk);
    lu_hazard = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("rst_in_out", {10'd0, outs}, {10'd0, O_RST});
    chk_stall("rst");
    @(negedge clk);
    rst_n = 1'b1;
    lu_hazard = 1'b0;
    branch_taken = 1'b0;

    cyc("idle0", 0, 0, 0, 0, O_DEF, S_RUN);
    // single load-use hazard
    cyc("lu1",   1, 0, 0, 0, O_LU,  S_RUN);
    cyc("lu1_b", 0, 0, 0, 0, O_DEF, S_LU);
    cyc("lu1_r", 0, 0, 0, 0, O_DEF, S_RUN);
    // back-to-back load-use hazards
    cyc("bb_a",  1, 0, 0, 0, O_LU,  S_RUN);
    cyc("bb_ab", 1, 0, 0, 0, O_DEF, S_LU);
    cyc("bb_b",  1, 0, 0, 0, O_LU,  S_RUN);
    cyc("bb_bb", 0, 0, 0, 0, O_DEF, S_LU);
    cyc("bb_r",  0, 0, 0, 0, O_DEF, S_RUN);
    // three wait cycles then ready
    cyc("mw_1",  0, 0, 1, 0, O_FRZ, S_RUN);
    cyc("mw_2",  0, 0, 1, 0, O_FRZ, S_MW);
    cyc("mw_3",  0, 0, 1, 0, O_FRZ, S_MW);
    cyc("mw_rel", 0, 0, 1, 1, O_DEF, S_MW);
    cyc("mw_r",  0, 0, 0, 0, O_DEF, S_RUN);
    // memory wait beats branch; branch ignored while frozen, honoured on release
    cyc("mwb_1", 1, 1, 1, 0, O_FRZ, S_RUN);
    cyc("mwb_2", 1, 1, 1, 0, O_FRZ, S_MW);
    cyc("mwb_rel", 1, 1, 1, 1, O_BR, S_MW);
    cyc("mwb_fl", 0, 0, 0, 0, O_FL, S_FL);
    cyc("mwb_r", 0, 0, 0, 0, O_DEF, S_RUN);
    // load-use on release cycle
    cyc("mwl_1", 0, 0, 1, 0, O_FRZ, S_RUN);
    cyc("mwl_rel", 1, 0, 1, 1, O_LU, S_MW);
    cyc("mwl_b", 0, 0, 0, 0, O_DEF, S_LU);
    cyc("mwl_r", 0, 0, 0, 0, O_DEF, S_RUN);
    // branch beats load-use; flush ignores all inputs
    cyc("br_1",  1, 1, 0, 0, O_BR,  S_RUN);
    cyc("br_fl", 1, 1, 1, 0, O_FL,  S_FL);
    cyc("br_r",  0, 0, 0, 0, O_DEF, S_RUN);
    // memory wait and branch still act from the bubble
    cyc("lum_1", 1, 0, 0, 0, O_LU,  S_RUN);
    cyc("lum_2", 1, 0, 1, 0, O_FRZ, S_LU);
    cyc("lum_rel", 0, 0, 1, 1, O_DEF, S_MW);
    cyc("lum_r", 0, 0, 0, 0, O_DEF, S_RUN);
    cyc("lub_1", 1, 0, 0, 0, O_LU,  S_RUN);
    cyc("lub_2", 1, 1, 0, 0, O_BR,  S_LU);
    cyc("lub_fl", 0, 0, 0, 0, O_FL, S_FL);
    cyc("lub_r", 0, 0, 0, 0, O_DEF, S_RUN);
    // timeout after four MEM_WAIT cycles
    cyc("to_0",  0, 0, 1, 0, O_FRZ, S_RUN);
    cyc("to_1",  0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to_2",  0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to_3",  0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to_4",  0, 0, 1, 0, O_ERR, S_MW);
    cyc("to_r",  0, 0, 0, 0, O_DEF, S_RUN);
    // counter restarts on re-entry: full four cycles again before timeout
    cyc("to2_0", 0, 0, 1, 0, O_FRZ, S_RUN);
    cyc("to2_1", 0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to2_2", 0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to2_3", 0, 0, 1, 0, O_FRZ, S_MW);
    cyc("to2_4", 0, 0, 1, 0, O_ERR, S_MW);
    cyc("to2_r", 0, 0, 0, 0, O_DEF, S_RUN);
    // reset in the middle of a memory wait
    cyc("rmw_1", 0, 0, 1, 0, O_FRZ, S_RUN);
    cyc("rmw_2", 0, 0, 1, 0, O_FRZ, S_MW);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    stall_exp = 0;
    chk("rmw_rst_out", {10'd0, outs}, {10'd0, O_RST});
    chk("rmw_rst_st", {14'd0, dbg_state}, {14'd0, S_RUN});
    chk_stall("rmw_rst");
    @(negedge clk);
    chk("rmw_hold_out", {10'd0, outs}, {10'd0, O_RST});
    rst_n = 1'b1;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("rmw_rel_out", {10'd0, outs}, {10'd0, O_DEF});
    cyc("rmw_r", 0, 0, 0, 0, O_DEF, S_RUN);
    cyc("rmw_r2", 0, 0, 0, 0, O_DEF, S_RUN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
